// File: rtl/core_prefetch_queue_pkg.sv
// core_prefetch_queue_pkg: shared core uarch types and instruction constants
package core_prefetch_queue_pkg;
  localparam int PTR_W = 16;
  typedef logic [31:0] word;
  typedef logic [15:0] hword;
  typedef logic [PTR_W-1:0] ptr;
  typedef logic [PTR_W:0] hptr;
  localparam hword NOP = 16'h0001;
  localparam hword DNOP = 16'h0000;
endpackage

// File: rtl/core_prefetch_queue_fifo.sv
// core_prefetch_fifo: DEPTH-word circular buffer with push/pop/clear and occupancy count
module core_prefetch_fifo
  import core_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  word           wdata,
  output word           rdata,
  output logic [CW-1:0] count
);
  word mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = !clr && pop && count_q != '0;
    do_push = !clr && push && (count_q != CW'(DEPTH) || do_pop);
    wr_d = clr ? '0 : wr_q + AW'(do_push);
    rd_d = clr ? '0 : rd_q + AW'(do_pop);
    count_d = clr ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/core_prefetch_queue.sv
// core_prefetch_queue: instruction prefetch queue; define CORE_PREFETCH_BYPASS_EN to forward responses into an empty queue combinationally
module core_prefetch_queue
  import core_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  hptr  flush_target,
  input  logic stall,
  output logic req,
  output ptr   req_addr,
  input  logic req_ready,
  input  logic rsp_valid,
  input  word  rsp_data,
  output hword hi_insn,
  output hword lo_insn,
  output logic hi_valid,
  output logic lo_valid,
  output hptr  hi_insn_pc,
  output hptr  lo_insn_pc,
  output ptr   pair_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  logic [CW-1:0] count, outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  ptr req_addr_q, req_addr_d, pair_pc_q, pair_pc_d;
  logic split_q, split_d;
  word head, fifo_rdata;
  logic req_fire, rsp_ok, bypass_hit, present, consume, push, pop;
  core_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .push(push),
    .pop(pop),
    .wdata(rsp_data),
    .rdata(fifo_rdata),
    .count(count)
  );
  always_comb begin
    req = !flush && SW'(count) + SW'(outstanding_q) < SW'(DEPTH) && outstanding_q < CW'(MAX_OUTSTANDING);
    req_fire = req && req_ready;
    rsp_ok = rsp_valid && !flush && drop_cnt_q == '0;
`ifdef CORE_PREFETCH_BYPASS_EN
    bypass_hit = rsp_ok && count == '0;
`else
    bypass_hit = 1'b0;
`endif
    present = !flush && (count != '0 || bypass_hit);
    consume = present && !stall;
    head = count != '0 ? fifo_rdata : rsp_data;
    push = rsp_ok && !(bypass_hit && !stall);
    pop = consume && count != '0;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_valid);
    // words already in flight at a redirect are stale and must be discarded on arrival
    drop_cnt_d = flush ? outstanding_q - CW'(rsp_valid) : drop_cnt_q - CW'(rsp_valid && drop_cnt_q != '0);
    req_addr_d = flush ? flush_target[PTR_W:1] : req_addr_q + PTR_W'(req_fire);
    pair_pc_d = flush ? flush_target[PTR_W:1] : pair_pc_q + PTR_W'(consume);
    split_d = flush ? flush_target[0] : split_q && !consume;
    hi_valid = present && !split_q;
    lo_valid = present;
    hi_insn = !present ? DNOP : split_q ? NOP : head[31:16];
    lo_insn = !present ? DNOP : split_q ? head[31:16] : head[15:0];
    hi_insn_pc = {pair_pc_q, 1'b1};
    lo_insn_pc = {pair_pc_q, split_q};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      drop_cnt_q <= '0;
      req_addr_q <= '0;
      pair_pc_q <= '0;
      split_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q <= drop_cnt_d;
      req_addr_q <= req_addr_d;
      pair_pc_q <= pair_pc_d;
      split_q <= split_d;
    end
  end
  assign req_addr = req_addr_q;
  assign pair_pc = pair_pc_q;
  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_valid && outstanding_q == '0 && drop_cnt_q == '0));
endmodule

// File: tb/tb_core_prefetch_queue.sv
// tb_core_prefetch_queue: directed and random checks of the prefetch queue against a queue-based reference model
module tb_core_prefetch_queue;
  import core_prefetch_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
`ifdef CORE_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, stall = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0;
  logic req, hi_valid, lo_valid;
  hptr flush_target = '0, hi_insn_pc, lo_insn_pc;
  ptr req_addr, pair_pc;
  word rsp_data = '0;
  hword hi_insn, lo_insn;
  int n_cmp = 0, n_err = 0;
  typedef struct {ptr addr; bit stale;} pend_t;
  pend_t pend[$];
  word bufq[$];
  ptr m_raddr = '0, m_pc = '0;
  bit m_split = 1'b0;
  word w;
  core_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .flush_target(flush_target),
    .stall(stall),
    .req(req),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .hi_insn(hi_insn),
    .lo_insn(lo_insn),
    .hi_valid(hi_valid),
    .lo_valid(lo_valid),
    .hi_insn_pc(hi_insn_pc),
    .lo_insn_pc(lo_insn_pc),
    .pair_pc(pair_pc)
  );
  always #5 clk = ~clk;
  function automatic word mem(input ptr a);
    return {a ^ 16'hC35A, ~a};
  endfunction
  function automatic word next_rsp();
    return pend.size() > 0 ? mem(pend[0].addr) : 32'h0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit fl, input hptr tgt, input bit st, input bit rdy, input bit rv, input word rd);
    bit ok, byp, present, req_m, cons;
    word hw;
    @(negedge clk);
    flush = fl;
    flush_target = tgt;
    stall = st;
    req_ready = rdy;
    rsp_valid = rv;
    rsp_data = rd;
    #1;
    ok = rv && pend.size() > 0 && !fl && !pend[0].stale;
    byp = BYP && ok && bufq.size() == 0;
    present = !fl && (bufq.size() > 0 || byp);
    hw = bufq.size() > 0 ? bufq[0] : rd;
    req_m = !fl && pend.size() + bufq.size() < DEPTH && pend.size() < MAXO;
    chk("req", req, req_m);
    chk("req_addr", req_addr, m_raddr);
    chk("pair_pc", pair_pc, m_pc);
    chk("hi_valid", hi_valid, present && !m_split);
    chk("lo_valid", lo_valid, present);
    chk("hi_insn", hi_insn, !present ? DNOP : m_split ? NOP : hw[31:16]);
    chk("lo_insn", lo_insn, !present ? DNOP : m_split ? hw[31:16] : hw[15:0]);
    if (present) begin
      chk("lo_insn_pc", lo_insn_pc, m_split ? {m_pc, 1'b1} : {m_pc, 1'b0});
      if (!m_split) chk("hi_insn_pc", hi_insn_pc, {m_pc, 1'b1});
    end
    cons = present && !st;
    if (rv && pend.size() > 0) void'(pend.pop_front());
    if (req_m && rdy) begin
      pend.push_back('{m_raddr, 1'b0});
      m_raddr++;
    end
    if (ok) bufq.push_back(rd);
    if (cons) begin
      void'(bufq.pop_front());
      m_pc++;
      m_split = 1'b0;
    end
    if (fl) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      bufq.delete();
      m_pc = tgt[PTR_W:1];
      m_raddr = tgt[PTR_W:1];
      m_split = tgt[0];
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_hi_valid", hi_valid, 0);
    chk("rst_lo_valid", lo_valid, 0);
    chk("rst_hi_insn", hi_insn, DNOP);
    chk("rst_lo_insn", lo_insn, DNOP);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_pair_pc", pair_pc, 0);
    pend.delete();
    bufq.delete();
    m_raddr = '0;
    m_pc = '0;
    m_split = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    // in-order pair delivery after reset
    drive(0, '0, 0, 1, 0, '0);
    chk("first_req", req, 1);
    drive(0, '0, 0, 1, 1, 32'h11112222);
`ifdef CORE_PREFETCH_BYPASS_EN
    chk("byp_hi", hi_insn, 16'h1111);
    chk("byp_lo_valid", lo_valid, 1);
    drive(0, '0, 0, 0, 1, 32'h33334444);
    chk("byp_count0", dut.u_fifo.count, 0);
    chk("pair1_hi", hi_insn, 16'h3333);
    chk("pair1_pc", pair_pc, 1);
    drive(0, '0, 0, 0, 0, '0);
    chk("byp_empty", lo_valid, 0);
`else
    chk("nobyp_lo_valid", lo_valid, 0);
    drive(0, '0, 0, 0, 1, 32'h33334444);
    chk("pair0_hi", hi_insn, 16'h1111);
    chk("pair0_lo", lo_insn, 16'h2222);
    chk("pair0_pc", pair_pc, 0);
    drive(0, '0, 0, 0, 0, '0);
    chk("pair1_hi", hi_insn, 16'h3333);
    chk("pair1_pc", pair_pc, 1);
`endif
    drive(0, '0, 0, 0, 0, '0);
    // stall held: occupancy saturates at DEPTH
    do_reset();
    for (int i = 0; i < 12; i++) drive(0, '0, 1, 1, pend.size() > 0, next_rsp());
    chk("stall_req_low", req, 0);
    chk("stall_count", dut.u_fifo.count, 4);
    // flush with a response and a pop while 3 buffered + 1 in flight
    drive(0, '0, 0, 1, 0, '0);
    drive(0, '0, 1, 1, 0, '0);
    drive(1, 17'h80, 0, 1, 1, next_rsp());
    chk("flush_hi_valid", hi_valid, 0);
    chk("flush_lo_valid", lo_valid, 0);
    chk("flush_lo_insn", lo_insn, DNOP);
    drive(0, '0, 0, 0, 0, '0);
    chk("flush_count0", dut.u_fifo.count, 0);
    // flush to an odd halfword with 2 in flight
    do_reset();
    drive(0, '0, 1, 1, 0, '0);
    drive(0, '0, 1, 1, 0, '0);
    drive(1, 17'h21, 0, 1, 0, '0);
    drive(0, '0, 0, 1, 1, next_rsp());
    drive(0, '0, 0, 1, 1, next_rsp());
    drive(0, '0, 1, 0, 1, next_rsp());
    drive(0, '0, 1, 0, 0, '0);
    w = mem(16'h10);
    chk("split_lo_valid", lo_valid, 1);
    chk("split_hi_valid", hi_valid, 0);
    chk("split_lo_pc", lo_insn_pc, 17'h21);
    chk("split_pair_pc", pair_pc, 16'h10);
    chk("split_lo_insn", lo_insn, w[31:16]);
    // reset mid-stream with 3 buffered
    for (int i = 0; i < 20 && bufq.size() < 3; i++) drive(0, '0, 1, 1, pend.size() > 0, next_rsp());
    chk("pre_reset_valid", lo_valid, 1);
    do_reset();
    // random traffic with redirects
    for (int i = 0; i < 800; i++) begin
      bit fl, rv;
      fl = $urandom_range(0, 19) == 0;
      rv = pend.size() > 0 && $urandom_range(0, 1) == 1;
      drive(fl, hptr'($urandom_range(0, 17'h1FFFF)), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, rv, next_rsp());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
